multicycle_main_control: RTL and testbench
==========================================

Name: multicycle_main_control

Overview:
- Main control FSM for the multi-cycle MIPS datapath; the producer side of the 2-bit alu_op interface consumed by the ALU control decoder.
- Decodes the 6-bit opcode and sequences fetch, decode, execute, memory and writeback.
- Drives every datapath enable and mux select.
- Stalls on a memory ready handshake.

Parameters:
WAIT_MEM, 1, 1: memory states hold until mem_ready=1; 0: mem_ready ignored (treated as 1)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
opcode  in  6  instruction[31:26] from instruction register
mem_ready  in  1  memory access completes this cycle
pc_write  out  1  unconditional PC load
pc_write_cond  out  1  PC load if ALU zero
i_or_d  out  1  memory address select: 0=PC, 1=ALUOut
mem_read  out  1  memory read strobe
mem_write  out  1  memory write strobe
ir_write  out  1  instruction register load
mem_to_reg  out  1  writeback select: 0=ALUOut, 1=MDR
reg_dst  out  1  destination select: 0=rt, 1=rd
reg_write  out  1  register file write enable
alu_src_a  out  1  0=PC, 1=A
alu_src_b  out  2  00=B, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2
alu_op  out  2  00=add, 01=subtract, 10=use funct
pc_source  out  2  00=ALU result, 01=ALUOut, 10=jump target
instr_done  out  1  one-cycle pulse in the final cycle of each instruction
illegal_op  out  1  sticky flag: undefined opcode decoded
state  out  4  current state encoding (debug)

Behaviour:
- Reset is asynchronous and active-low: rst_n=0 forces state=IDLE(0) and illegal_op=0. All other outputs are Moore-decoded from state, so every output is 0 while in reset.
- IDLE goes to FETCH on the first rising edge with rst_n=1.
- Opcodes: R=000000, LW=100011, SW=101011, BEQ=000100, J=000010, ADDI=001000. Any other opcode is illegal.
- State encodings and asserted outputs (unlisted outputs are 0):
  - FETCH(1): mem_read=1, alu_src_b=01, alu_op=00. ir_write=pc_write=mem_ready (Mealy-qualified). Advances to DECODE only when mem_ready=1; otherwise holds.
  - DECODE(2): alu_src_b=11, alu_op=00. Next state: LW/SW -> MEM_ADDR; R -> R_EXEC; BEQ -> BRANCH; J -> JUMP; ADDI -> ADDI_EXEC; illegal -> FETCH, setting illegal_op=1.
  - MEM_ADDR(3): alu_src_a=1, alu_src_b=10, alu_op=00. Next state: LW -> MEM_READ; SW -> MEM_WRITE.
  - MEM_READ(4): mem_read=1, i_or_d=1. Holds until mem_ready, then -> MEM_WB.
  - MEM_WB(5): reg_write=1, mem_to_reg=1, reg_dst=0, instr_done=1. Next state FETCH.
  - MEM_WRITE(6): mem_write=1, i_or_d=1. Holds until mem_ready. instr_done=mem_ready. Then -> FETCH.
  - R_EXEC(7): alu_src_a=1, alu_src_b=00, alu_op=10. Next state R_WB.
  - R_WB(8): reg_dst=1, reg_write=1, instr_done=1. Next state FETCH.
  - BRANCH(9): alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01, instr_done=1. Next state FETCH.
  - JUMP(10): pc_write=1, pc_source=10, instr_done=1. Next state FETCH.
  - ADDI_EXEC(11): alu_src_a=1, alu_src_b=10, alu_op=00. Next state ADDI_WB.
  - ADDI_WB(12): reg_write=1, reg_dst=0, instr_done=1. Next state FETCH.
  - Encodings 13-15 are unreachable; if entered, next state is FETCH and all outputs are 0.
- Cycle counts with mem_ready constantly 1:
  - LW = 5 cycles.
  - SW, R, ADDI = 4 cycles.
  - BEQ, J = 3 cycles.
  - Each extra cycle of mem_ready=0 in a memory state adds exactly one cycle.
- mem_write and mem_read are never both 1. reg_write and pc_write are never both 1.
- opcode is sampled only in DECODE and MEM_ADDR; it must be stable from IR load onward.
- illegal_op stays set until the next reset. The FSM continues to fetch after an illegal opcode.
- rst_n asserted mid-instruction returns the FSM to IDLE immediately, with no partial write strobes after the reset edge.

Test Plan:
1. Reset, then release; mem_ready=1, opcode=100011 -> state sequence 0,1,2,3,4,5,1. reg_write=1 and mem_to_reg=1 only in state 5. instr_done pulses once.
2. R-type (000000) -> states 1,2,7,8. alu_op=10 in state 7 only. reg_dst=1 and reg_write=1 in state 8.
3. BEQ (000100) -> states 1,2,9. In state 9: alu_op=01, pc_write_cond=1, pc_source=01. Then J (000010): state 10 with pc_write=1, pc_source=10.
4. SW (101011) with mem_ready held 0 for 3 cycles in FETCH and 2 cycles in MEM_WRITE:
   - FETCH lasts 4 cycles; ir_write is asserted only in its last cycle.
   - MEM_WRITE lasts 3 cycles with mem_write=1 throughout; instr_done is 1 only in its last cycle.
5. opcode=111111 in DECODE -> next state FETCH, illegal_op=1 and stays 1 through a following ADDI (states 11, 12). Cleared only by rst_n=0.
6. rst_n driven low asynchronously mid-MEM_WRITE -> mem_write=0 and state=0 before the next clock edge. Two cycles after release, state=1 with mem_read=1.

Source files
------------

// File: rtl/multicycle_main_control_if.sv
// Control bundle between the multi-cycle main control FSM and the datapath.
// The FSM (master) reads the opcode and memory ready. It drives every
// datapath enable, mux select and status flag.
//
// Memory handshake: the FSM holds mem_read or mem_write high for as long as
// it stays in a memory state. The access completes in the cycle where
// mem_ready=1 is seen together with the strobe, and the FSM leaves the state
// on that clock edge. The memory may keep mem_ready low for any number of
// cycles. The FSM never drops a strobe before mem_ready, except on reset.
interface multicycle_main_control_if;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write;
  logic       pc_write_cond;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       mem_to_reg;
  logic       reg_dst;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] pc_source;
  logic       instr_done;
  logic       illegal_op;
  logic [3:0] state;

  modport master (
    input  opcode, mem_ready,
    output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, instr_done, illegal_op, state
  );

  modport slave (
    output opcode, mem_ready,
    input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, instr_done, illegal_op, state
  );
endinterface

// File: rtl/multicycle_main_control.sv
// Main control FSM for the multi-cycle MIPS datapath. It sequences fetch,
// decode, execute, memory and writeback. Outputs are Moore-decoded from the
// state. The exceptions are the fetch load enables and the store-done pulse,
// which are qualified by mem_ready.
module multicycle_main_control #(
  parameter bit WAIT_MEM = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  multicycle_main_control_if.master     bus
);

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_FETCH     = 4'd1;
  localparam logic [3:0] S_DECODE    = 4'd2;
  localparam logic [3:0] S_MEM_ADDR  = 4'd3;
  localparam logic [3:0] S_MEM_READ  = 4'd4;
  localparam logic [3:0] S_MEM_WB    = 4'd5;
  localparam logic [3:0] S_MEM_WRITE = 4'd6;
  localparam logic [3:0] S_R_EXEC    = 4'd7;
  localparam logic [3:0] S_R_WB      = 4'd8;
  localparam logic [3:0] S_BRANCH    = 4'd9;
  localparam logic [3:0] S_JUMP      = 4'd10;
  localparam logic [3:0] S_ADDI_EXEC = 4'd11;
  localparam logic [3:0] S_ADDI_WB   = 4'd12;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  logic [3:0] state_q, state_d;
  logic       illegal_q, illegal_d;
  logic       mem_rdy;

  // With WAIT_MEM=0 the memory is assumed to complete every access at once.
  assign mem_rdy = WAIT_MEM ? bus.mem_ready : 1'b1;

  // State and sticky illegal-opcode flag. Reset drops straight to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  // Next-state logic. The opcode is only looked at in DECODE and MEM_ADDR.
  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    case (state_q)
      S_IDLE:      state_d = S_FETCH;
      S_FETCH:     if (mem_rdy) state_d = S_DECODE;
      S_DECODE: begin
        case (bus.opcode)
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_R:         state_d = S_R_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_ADDI_EXEC;
          default: begin
            state_d   = S_FETCH;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_MEM_ADDR:  state_d = (bus.opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ:  if (mem_rdy) state_d = S_MEM_WB;
      S_MEM_WB:    state_d = S_FETCH;
      S_MEM_WRITE: if (mem_rdy) state_d = S_FETCH;
      S_R_EXEC:    state_d = S_R_WB;
      S_R_WB:      state_d = S_FETCH;
      S_BRANCH:    state_d = S_FETCH;
      S_JUMP:      state_d = S_FETCH;
      S_ADDI_EXEC: state_d = S_ADDI_WB;
      S_ADDI_WB:   state_d = S_FETCH;
      default:     state_d = S_FETCH;
    endcase
  end

  // Datapath control decode. Every output is 0 unless a state asserts it.
  always_comb begin
    bus.pc_write      = 1'b0;
    bus.pc_write_cond = 1'b0;
    bus.i_or_d        = 1'b0;
    bus.mem_read      = 1'b0;
    bus.mem_write     = 1'b0;
    bus.ir_write      = 1'b0;
    bus.mem_to_reg    = 1'b0;
    bus.reg_dst       = 1'b0;
    bus.reg_write     = 1'b0;
    bus.alu_src_a     = 1'b0;
    bus.alu_src_b     = 2'b00;
    bus.alu_op        = 2'b00;
    bus.pc_source     = 2'b00;
    bus.instr_done    = 1'b0;
    case (state_q)
      S_FETCH: begin
        bus.mem_read  = 1'b1;
        bus.alu_src_b = 2'b01;
        bus.ir_write  = mem_rdy;
        bus.pc_write  = mem_rdy;
      end
      S_DECODE: bus.alu_src_b = 2'b11;
      S_MEM_ADDR: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
      end
      S_MEM_READ: begin
        bus.mem_read = 1'b1;
        bus.i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        bus.reg_write  = 1'b1;
        bus.mem_to_reg = 1'b1;
        bus.instr_done = 1'b1;
      end
      S_MEM_WRITE: begin
        bus.mem_write  = 1'b1;
        bus.i_or_d     = 1'b1;
        bus.instr_done = mem_rdy;
      end
      S_R_EXEC: begin
        bus.alu_src_a = 1'b1;
        bus.alu_op    = 2'b10;
      end
      S_R_WB: begin
        bus.reg_dst    = 1'b1;
        bus.reg_write  = 1'b1;
        bus.instr_done = 1'b1;
      end
      S_BRANCH: begin
        bus.alu_src_a     = 1'b1;
        bus.alu_op        = 2'b01;
        bus.pc_write_cond = 1'b1;
        bus.pc_source     = 2'b01;
        bus.instr_done    = 1'b1;
      end
      S_JUMP: begin
        bus.pc_write   = 1'b1;
        bus.pc_source  = 2'b10;
        bus.instr_done = 1'b1;
      end
      S_ADDI_EXEC: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
      end
      S_ADDI_WB: begin
        bus.reg_write  = 1'b1;
        bus.instr_done = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.state      = state_q;
  assign bus.illegal_op = illegal_q;

endmodule

// File: tb/tb_multicycle_main_control.sv
// Directed bench for the multi-cycle main control FSM. It steps the FSM
// through each instruction class and compares every control output against
// a hand-written per-state table. The table holds the mem_ready=1 values.
module tb_multicycle_main_control;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  multicycle_main_control_if bus ();

  multicycle_main_control #(.WAIT_MEM(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_BAD  = 6'b111111;

  // Field order of the control vector:
  // {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
  //  mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b[1:0],
  //  alu_op[1:0], pc_source[1:0], instr_done}
  logic [16:0] exp_ctl [0:12];

  int n_checks;
  int n_pass;
  int done_cnt;

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else
      n_pass++;
  endtask

  function automatic logic [16:0] ctl_now();
    return {bus.pc_write, bus.pc_write_cond, bus.i_or_d, bus.mem_read,
            bus.mem_write, bus.ir_write, bus.mem_to_reg, bus.reg_dst,
            bus.reg_write, bus.alu_src_a, bus.alu_src_b, bus.alu_op,
            bus.pc_source, bus.instr_done};
  endfunction

  // ---------------- driver tasks ----------------
  // Move to 2 ns after the next rising edge, where inputs are driven.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic expect_state(input string tag, input logic [3:0] st);
    #1;
    check({tag, "/state"}, 32'(bus.state), 32'(st));
    check({tag, "/ctl"}, 32'(ctl_now()), 32'(exp_ctl[st]));
    if (bus.instr_done) done_cnt++;
  endtask

  task automatic step(input string tag, input logic [3:0] st);
    tick();
    expect_state(tag, st);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_checks = 0;
    n_pass   = 0;
    done_cnt = 0;
    exp_ctl[0]  = 17'b0_0_0_0_0_0_0_0_0_0_00_00_00_0;
    exp_ctl[1]  = 17'b1_0_0_1_0_1_0_0_0_0_01_00_00_0;
    exp_ctl[2]  = 17'b0_0_0_0_0_0_0_0_0_0_11_00_00_0;
    exp_ctl[3]  = 17'b0_0_0_0_0_0_0_0_0_1_10_00_00_0;
    exp_ctl[4]  = 17'b0_0_1_1_0_0_0_0_0_0_00_00_00_0;
    exp_ctl[5]  = 17'b0_0_0_0_0_0_1_0_1_0_00_00_00_1;
    exp_ctl[6]  = 17'b0_0_1_0_1_0_0_0_0_0_00_00_00_1;
    exp_ctl[7]  = 17'b0_0_0_0_0_0_0_0_0_1_00_10_00_0;
    exp_ctl[8]  = 17'b0_0_0_0_0_0_0_1_1_0_00_00_00_1;
    exp_ctl[9]  = 17'b0_1_0_0_0_0_0_0_0_1_00_01_01_1;
    exp_ctl[10] = 17'b1_0_0_0_0_0_0_0_0_0_00_00_10_1;
    exp_ctl[11] = 17'b0_0_0_0_0_0_0_0_0_1_10_00_00_0;
    exp_ctl[12] = 17'b0_0_0_0_0_0_0_0_1_0_00_00_00_1;

    rst_n         = 1'b0;
    bus.mem_ready = 1'b1;
    bus.opcode    = OP_LW;

    // Reset state
    repeat (2) @(posedge clk);
    #2;
    expect_state("reset", 4'd0);
    check("reset/illegal", 32'(bus.illegal_op), 32'd0);
    rst_n = 1'b1;

    // 1. LW: 1,2,3,4,5 then back to FETCH
    done_cnt = 0;
    step("lw_fetch", 4'd1);
    step("lw_decode", 4'd2);
    step("lw_addr", 4'd3);
    step("lw_read", 4'd4);
    step("lw_wb", 4'd5);
    step("lw_next_fetch", 4'd1);
    check("lw_done_pulses", 32'(done_cnt), 32'd1);

    // 2. R-type: 2,7,8 then FETCH
    bus.opcode = OP_R;
    step("r_decode", 4'd2);
    step("r_exec", 4'd7);
    step("r_wb", 4'd8);
    step("r_next_fetch", 4'd1);

    // 3. BEQ then J
    bus.opcode = OP_BEQ;
    step("beq_decode", 4'd2);
    step("beq_branch", 4'd9);
    step("beq_next_fetch", 4'd1);
    bus.opcode = OP_J;
    step("j_decode", 4'd2);
    step("j_jump", 4'd10);
    step("j_next_fetch", 4'd1);

    // 4. SW with FETCH stalled 3 cycles and MEM_WRITE stalled 2 cycles
    bus.opcode    = OP_SW;
    bus.mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i != 0) tick();
      #1;
      check($sformatf("sw_fetch_stall%0d/state", i), 32'(bus.state), 32'd1);
      check($sformatf("sw_fetch_stall%0d/ir_write", i), 32'(bus.ir_write), 32'd0);
      check($sformatf("sw_fetch_stall%0d/mem_read", i), 32'(bus.mem_read), 32'd1);
    end
    tick();
    bus.mem_ready = 1'b1;
    expect_state("sw_fetch_last", 4'd1);
    step("sw_decode", 4'd2);
    step("sw_addr", 4'd3);
    tick();
    bus.mem_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if (i != 0) tick();
      #1;
      check($sformatf("sw_write_stall%0d/state", i), 32'(bus.state), 32'd6);
      check($sformatf("sw_write_stall%0d/mem_write", i), 32'(bus.mem_write), 32'd1);
      check($sformatf("sw_write_stall%0d/instr_done", i), 32'(bus.instr_done), 32'd0);
    end
    tick();
    bus.mem_ready = 1'b1;
    expect_state("sw_write_last", 4'd6);
    step("sw_next_fetch", 4'd1);

    // 5. Illegal opcode, then ADDI with the flag still set
    bus.opcode = OP_BAD;
    step("bad_decode", 4'd2);
    check("bad_decode/illegal", 32'(bus.illegal_op), 32'd0);
    step("bad_refetch", 4'd1);
    check("bad_refetch/illegal", 32'(bus.illegal_op), 32'd1);
    bus.opcode = OP_ADDI;
    step("addi_decode", 4'd2);
    step("addi_exec", 4'd11);
    check("addi_exec/illegal", 32'(bus.illegal_op), 32'd1);
    step("addi_wb", 4'd12);
    step("addi_next_fetch", 4'd1);
    check("addi_done/illegal", 32'(bus.illegal_op), 32'd1);

    // 6. Asynchronous reset in the middle of MEM_WRITE
    bus.opcode = OP_SW;
    step("rst_sw_decode", 4'd2);
    step("rst_sw_addr", 4'd3);
    tick();
    bus.mem_ready = 1'b0;
    #1;
    check("rst_sw_write/state", 32'(bus.state), 32'd6);
    check("rst_sw_write/mem_write", 32'(bus.mem_write), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst/state", 32'(bus.state), 32'd0);
    check("async_rst/mem_write", 32'(bus.mem_write), 32'd0);
    check("async_rst/illegal", 32'(bus.illegal_op), 32'd0);
    tick();
    expect_state("rst_held", 4'd0);
    #2;
    rst_n = 1'b1;
    tick();
    #1;
    check("post_rst1/state", 32'(bus.state), 32'd1);
    tick();
    #1;
    check("post_rst2/state", 32'(bus.state), 32'd1);
    check("post_rst2/mem_read", 32'(bus.mem_read), 32'd1);
    check("post_rst2/ir_write", 32'(bus.ir_write), 32'd0);
    bus.mem_ready = 1'b1;
    #1;
    check("post_rst2/ir_write_rdy", 32'(bus.ir_write), 32'd1);

    // ---------------- final report ----------------
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
